bus_generator_arbiter: RTL and testbench

- Shared-bus generator and arbiter connecting DRVRS device FIFOs on each of BITS independent buses.
- For each bus, the block round-robin selects one device with a pending packet and pops its packet.
- It then pushes that packet into the destination device(s) named by the packet's ID field.
- It sits between the device-side FIFO interface and the device agents.

---
 rtl/bus_gen_pkg.sv | 19 +
 rtl/bus_generator_arbiter_if.sv | 20 ++
 rtl/bus_arbiter_lane.sv | 97 +++++++++
 rtl/bus_generator_arbiter.sv | 42 ++++
 tb/tb_bus_generator_arbiter.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_gen_pkg.sv
// Shared types and constants for the bus generator/arbiter: ID field width,
// lane FSM states and the packet-ID extraction helper.
package bus_gen_pkg;

  localparam int ID_W = 8;
  localparam logic [ID_W-1:0] BROADCAST_DEF = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    PUSH = 2'd2
  } state_e;

  // Destination ID lives in the top ID_W bits of a pkt_w-wide packet.
  function automatic logic [ID_W-1:0] pkt_id(input logic [63:0] pkt, input int unsigned pkt_w);
    return ID_W'(pkt >> (pkt_w - ID_W));
  endfunction

endpackage

// File: rtl/bus_generator_arbiter_if.sv
// Device-side FIFO bus bundle for all lanes of the bus generator/arbiter.
interface bus_generator_arbiter_if #(
  parameter int BITS    = 1,
  parameter int DRVRS   = 4,
  parameter int PCKG_SZ = 16
);

  // Handshake: pndng high means D_pop holds a valid head packet; pop is a
  // one-cycle strobe that consumes that head; push is a one-cycle strobe that
  // tells the addressed device(s) to take D_push. No backpressure on push.
  logic [BITS-1:0][DRVRS-1:0]              pndng;
  logic [BITS-1:0][DRVRS-1:0]              pop;
  logic [BITS-1:0][DRVRS-1:0]              push;
  logic [BITS-1:0][DRVRS-1:0][PCKG_SZ-1:0] D_pop;
  logic [BITS-1:0][DRVRS-1:0][PCKG_SZ-1:0] D_push;

  modport master (input pndng, D_pop, output pop, push, D_push);
  modport slave  (output pndng, D_pop, input pop, push, D_push);

endinterface

// File: rtl/bus_arbiter_lane.sv
// One bus lane: round-robin source select, IDLE->POP->PUSH transfer FSM,
// packet register and destination decode (unicast, broadcast, or drop).
module bus_arbiter_lane import bus_gen_pkg::*; #(
  parameter int               DRVRS     = 4,
  parameter int               PCKG_SZ   = 16,
  parameter logic [ID_W-1:0]  BROADCAST = BROADCAST_DEF
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [DRVRS-1:0]                pndng,
  input  logic [DRVRS-1:0][PCKG_SZ-1:0]   d_pop,
  output logic [DRVRS-1:0]                pop,
  output logic [DRVRS-1:0]                push,
  output logic [DRVRS-1:0][PCKG_SZ-1:0]   d_push,
  output state_e                          dbg_state
);

  localparam int PTR_W = (DRVRS > 1) ? $clog2(DRVRS) : 1;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   src_q, src_d;
  logic [PCKG_SZ-1:0] data_q, data_d;
  logic [PTR_W-1:0]   pick;
  logic [PTR_W-1:0]   cand_p;
  logic               pick_vld;
  int unsigned        cand;
  logic [ID_W-1:0]    dst_id;

  // Scan from ptr+DRVRS down to ptr+1 so the nearest pending device after ptr wins.
  always_comb begin
    pick     = ptr_q;
    pick_vld = 1'b0;
    cand     = 0;
    cand_p   = '0;
    for (int i = DRVRS; i >= 1; i--) begin
      cand   = (int'(ptr_q) + i) % DRVRS;
      cand_p = PTR_W'(cand);
      if (pndng[cand_p]) begin
        pick     = cand_p;
        pick_vld = 1'b1;
      end
    end
  end

  assign dst_id = pkt_id(64'(data_q), PCKG_SZ);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    src_d   = src_q;
    data_d  = data_q;
    pop     = '0;
    push    = '0;
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          src_d   = pick;
          state_d = POP;
        end
      end
      POP: begin
        pop[src_q] = 1'b1;
        data_d     = d_pop[src_q];
        ptr_d      = src_q;
        state_d    = PUSH;
      end
      PUSH: begin
        // Out-of-range, non-broadcast IDs leave push clear: the packet is dropped.
        for (int d = 0; d < DRVRS; d++) begin
          if (dst_id == BROADCAST) push[d] = (PTR_W'(d) != src_q);
          else if (int'(dst_id) == d) push[d] = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= PTR_W'(DRVRS - 1);
      src_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      src_q   <= src_d;
      data_q  <= data_d;
    end
  end

  assign d_push    = {DRVRS{data_q}};
  assign dbg_state = state_q;

endmodule

// File: rtl/bus_generator_arbiter.sv
// Shared-bus generator/arbiter: BITS independent lanes, each moving packets
// from device FIFOs to the device(s) addressed by the packet ID.
module bus_generator_arbiter import bus_gen_pkg::*; #(
  parameter int              BITS      = 1,
  parameter int              DRVRS     = 4,
  parameter int              PCKG_SZ   = 16,
  parameter logic [ID_W-1:0] BROADCAST = BROADCAST_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  bus_generator_arbiter_if.master bus,
  output logic [BITS-1:0][1:0]  dbg_state
);

  logic [BITS-1:0][DRVRS-1:0]              pop_w;
  logic [BITS-1:0][DRVRS-1:0]              push_w;
  logic [BITS-1:0][DRVRS-1:0][PCKG_SZ-1:0] d_push_w;
  state_e                                  lane_state [BITS];

  for (genvar g = 0; g < BITS; g++) begin : g_lane
    bus_arbiter_lane #(
      .DRVRS     (DRVRS),
      .PCKG_SZ   (PCKG_SZ),
      .BROADCAST (BROADCAST)
    ) u_lane (
      .clk       (clk),
      .reset     (reset),
      .pndng     (bus.pndng[g]),
      .d_pop     (bus.D_pop[g]),
      .pop       (pop_w[g]),
      .push      (push_w[g]),
      .d_push    (d_push_w[g]),
      .dbg_state (lane_state[g])
    );
    assign dbg_state[g] = lane_state[g];
  end

  assign bus.pop    = pop_w;
  assign bus.push   = push_w;
  assign bus.D_push = d_push_w;

endmodule

// File: tb/tb_bus_generator_arbiter.sv
// Self-checking bench for bus_generator_arbiter: device FIFO model, per-lane
// expected-transfer queues and a negedge monitor that pops and compares.
module tb_bus_generator_arbiter;
  import bus_gen_pkg::*;

  localparam int BITS    = 2;
  localparam int DRVRS   = 4;
  localparam int PCKG_SZ = 16;
  localparam int REC_W   = 2 * DRVRS + PCKG_SZ;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic [BITS-1:0][1:0] dbg_state;
  int   cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  bus_generator_arbiter_if #(.BITS(BITS), .DRVRS(DRVRS), .PCKG_SZ(PCKG_SZ)) bus ();

  bus_generator_arbiter #(
    .BITS(BITS), .DRVRS(DRVRS), .PCKG_SZ(PCKG_SZ), .BROADCAST(8'hFF)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- checking ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  // ---------------- device FIFO model ----------------
  int unsigned        dev_cnt  [BITS][DRVRS];
  logic [PCKG_SZ-1:0] dev_data [BITS][DRVRS];

  task automatic drive_pins();
    for (int l = 0; l < BITS; l++)
      for (int d = 0; d < DRVRS; d++) begin
        bus.pndng[l][d] = (dev_cnt[l][d] != 0);
        bus.D_pop[l][d] = dev_data[l][d];
      end
  endtask

  task automatic set_dev(input int l, input int d, input logic [PCKG_SZ-1:0] data, input int unsigned cnt);
    dev_data[l][d] = data;
    dev_cnt[l][d]  = cnt;
    drive_pins();
  endtask

  // ---------------- scoreboard ----------------
  logic [REC_W-1:0] exp_q0[$];
  logic [REC_W-1:0] exp_q1[$];
  logic [DRVRS-1:0]   exp_push  [BITS];
  logic [PCKG_SZ-1:0] exp_data  [BITS];
  logic               pend_push [BITS];
  logic               chk_idle  [BITS];
  int                 last_pop  [BITS];
  logic               gap_en = 1'b0;

  function automatic logic [DRVRS-1:0] push_of(input logic [7:0] id, input int src);
    logic [DRVRS-1:0] v;
    v = '0;
    if (id == 8'hFF) begin
      v = '1;
      v[src] = 1'b0;
    end else if (int'(id) < DRVRS) begin
      v[id[1:0]] = 1'b1;
    end
    return v;
  endfunction

  task automatic queue_pkt(input int l, input int src, input logic [PCKG_SZ-1:0] data);
    logic [DRVRS-1:0] pv;
    logic [REC_W-1:0] rec;
    pv = '0;
    pv[src] = 1'b1;
    rec = {pv, push_of(data[PCKG_SZ-1 -: 8], src), data};
    if (l == 0) exp_q0.push_back(rec);
    else        exp_q1.push_back(rec);
  endtask

  task automatic monitor_lane(input int l);
    logic [DRVRS-1:0] pv, hv;
    logic [REC_W-1:0] rec;
    logic             have;
    pv = bus.pop[l];
    hv = bus.push[l];
    if (chk_idle[l]) begin
      check_eq("idle_after_push", 64'(dbg_state[l]), 64'(IDLE));
      chk_idle[l] = 1'b0;
    end
    if (pend_push[l]) begin
      check_eq("push_vec", 64'(hv), 64'(exp_push[l]));
      for (int d = 0; d < DRVRS; d++) check_eq("d_push", 64'(bus.D_push[l][d]), 64'(exp_data[l]));
      check_eq("pop_during_push", 64'(pv), 64'(0));
      pend_push[l] = 1'b0;
      chk_idle[l]  = 1'b1;
    end else if (pv != '0) begin
      check_eq("push_during_pop", 64'(hv), 64'(0));
      have = (l == 0) ? (exp_q0.size() != 0) : (exp_q1.size() != 0);
      if (!have) begin
        check_eq("unexpected_pop", 64'(pv), 64'(0));
      end else begin
        rec = (l == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
        check_eq("pop_vec", 64'(pv), 64'(rec[REC_W-1 -: DRVRS]));
        exp_push[l]  = rec[PCKG_SZ+DRVRS-1 -: DRVRS];
        exp_data[l]  = rec[PCKG_SZ-1:0];
        pend_push[l] = 1'b1;
        if (gap_en && last_pop[l] >= 0) check_eq("grant_gap", 64'(cyc - last_pop[l]), 64'(3));
        last_pop[l] = cyc;
      end
    end else if (hv != '0) begin
      check_eq("unexpected_push", 64'(hv), 64'(0));
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      for (int l = 0; l < BITS; l++) monitor_lane(l);
      for (int l = 0; l < BITS; l++)
        for (int d = 0; d < DRVRS; d++)
          if (bus.pop[l][d] && dev_cnt[l][d] != 0) dev_cnt[l][d]--;
    end else begin
      for (int l = 0; l < BITS; l++) begin
        pend_push[l] = 1'b0;
        chk_idle[l]  = 1'b0;
      end
    end
    drive_pins();
  end

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_drain(input int budget);
    int  n;
    logic done;
    n = 0;
    done = 1'b0;
    while (!done && n < budget) begin
      @(posedge clk);
      n++;
      done = (exp_q0.size() == 0) && (exp_q1.size() == 0) &&
             !pend_push[0] && !pend_push[1] && !chk_idle[0] && !chk_idle[1];
    end
    if (!done) check_eq("drain_timeout", 64'(1), 64'(0));
    repeat (4) @(posedge clk);
    #2;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] id_tab [6];
    logic       seen;
    int         src, ix;
    logic [PCKG_SZ-1:0] pkt;

    id_tab = '{8'h00, 8'h01, 8'h02, 8'h03, 8'hFF, 8'h09};
    for (int l = 0; l < BITS; l++) begin
      pend_push[l] = 1'b0;
      chk_idle[l]  = 1'b0;
      last_pop[l]  = -1;
      exp_push[l]  = '0;
      exp_data[l]  = '0;
      for (int d = 0; d < DRVRS; d++) begin
        dev_cnt[l][d]  = 0;
        dev_data[l][d] = '0;
      end
    end
    drive_pins();

    // reset state
    repeat (3) @(posedge clk);
    #2;
    for (int l = 0; l < BITS; l++) begin
      check_eq("rst_pop",    64'(bus.pop[l]),    64'(0));
      check_eq("rst_push",   64'(bus.push[l]),   64'(0));
      check_eq("rst_d_push", 64'(bus.D_push[l]), 64'(0));
      check_eq("rst_state",  64'(dbg_state[l]),  64'(IDLE));
    end
    @(negedge clk);
    reset = 1'b1;
    tick();

    // unicast: device 1 -> device 2
    queue_pkt(0, 1, 16'h02AB);
    set_dev(0, 1, 16'h02AB, 1);
    wait_drain(40);

    // broadcast from device 3
    queue_pkt(0, 3, 16'hFF55);
    set_dev(0, 3, 16'hFF55, 1);
    wait_drain(40);

    // invalid address: popped, never pushed
    queue_pkt(0, 0, 16'h07CC);
    set_dev(0, 0, 16'h07CC, 1);
    wait_drain(40);

    // reset while in POP
    set_dev(0, 2, 16'h0312, 1);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (dbg_state[0] == POP) seen = 1'b1;
    end
    check_eq("rst_reach_pop", 64'(seen), 64'(1));
    reset = 1'b0;
    #1;
    check_eq("midrst_pop",    64'(bus.pop[0]),    64'(0));
    check_eq("midrst_push",   64'(bus.push[0]),   64'(0));
    check_eq("midrst_d_push", 64'(bus.D_push[0]), 64'(0));
    check_eq("midrst_state",  64'(dbg_state[0]),  64'(IDLE));
    set_dev(0, 2, 16'h0000, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    tick();

    // round-robin: 0,1,3 continuously pending; device 0 must be first
    gap_en = 1'b1;
    last_pop[0] = -1;
    for (int r = 0; r < 2; r++) begin
      queue_pkt(0, 0, 16'h0311);
      queue_pkt(0, 1, 16'h0022);
      queue_pkt(0, 3, 16'h0133);
    end
    set_dev(0, 0, 16'h0311, 2);
    set_dev(0, 1, 16'h0022, 2);
    set_dev(0, 3, 16'h0133, 2);
    wait_drain(60);
    gap_en = 1'b0;

    // multi-lane: both lanes busy together with different traffic
    queue_pkt(0, 0, 16'h0244);
    queue_pkt(0, 2, 16'h01A1);
    queue_pkt(1, 0, 16'h00C3);
    queue_pkt(1, 1, 16'hFFB2);
    set_dev(0, 0, 16'h0244, 1);
    set_dev(0, 2, 16'h01A1, 1);
    set_dev(1, 0, 16'h00C3, 1);
    set_dev(1, 1, 16'hFFB2, 1);
    wait_drain(60);

    // randomized single-source transfers on both lanes
    for (int it = 0; it < 8; it++) begin
      for (int l = 0; l < BITS; l++) begin
        src = $urandom_range(0, DRVRS - 1);
        ix  = $urandom_range(0, 5);
        pkt = {id_tab[ix], 8'($urandom_range(0, 255))};
        queue_pkt(l, src, pkt);
        set_dev(l, src, pkt, 1);
      end
      wait_drain(40);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    check_eq("global_timeout", 64'(1), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
